settings_cmd_writer: RTL and testbench
======================================

// Module: settings_cmd_writer
// PURPOSE
//  Front end of the settings store. Collects one 4-token "settings" command
//  (max_row, max_col, data_min, data_max) from the number-token parser.
//  Range-checks the command, then issues a single-cycle write strobe and the
//  four values to the settings register bank. Reports done or an error code
//  back to the UI/control FSM.
// PARAMETERS
//  MAX_DIM   32'sd5   largest legal row/col count (inclusive)
//  DATA_LO   -32'sd99 lowest legal data_min/data_max value
//  DATA_HI   32'sd99  highest legal data_min/data_max value
// PORTS
//  clk          in   1   single clock; all logic on posedge clk
//  rst          in   1   synchronous, active-high reset
//  start        in   1   pulse: open a new settings command (honoured in IDLE only)
//  tok_valid    in   1   token handshake valid
//  tok_ready    out  1   token handshake ready
//  tok_data     in   32  signed token value
//  tok_last     in   1   token is the last one on the input line
//  wr_en        out  1   one-cycle write strobe to settings registers
//  set_max_row  out  32  committed row limit (valid while wr_en=1)
//  set_max_col  out  32  committed col limit
//  data_min     out  32  committed element minimum
//  data_max     out  32  committed element maximum
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse, coincident with wr_en
//  error        out  1   one-cycle pulse on rejection
//  err_code     out  3   reason for the last rejection; held until next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0. All four value regs=0. wr_en=done=error=0, err_code=ERR_NONE, tok_ready=0.
//  - Handshake: a token transfers when tok_valid&&tok_ready. tok_ready=1 only in COLLECT and DRAIN.
//  - FSM states: IDLE, COLLECT, DRAIN, CHECK, COMMIT, FAIL.
//    IDLE:    start=1 -> COLLECT, idx=0, err_code=ERR_NONE. start in any other state is ignored.
//    COLLECT: each transfer stores tok_data into slot idx (0 row, 1 col, 2 min, 3 max); idx++.
//             tok_last with idx<3 -> FAIL, ERR_TOO_FEW.
//             idx==3, last=1 -> CHECK. idx==3, last=0 -> DRAIN.
//    DRAIN:   accept and discard tokens until a transfer with tok_last=1 -> FAIL, ERR_TOO_MANY.
//    CHECK:   one cycle, signed compares on the stored slots. First failing rule wins:
//             row<1 | row>MAX_DIM -> ERR_ROW
//             col<1 | col>MAX_DIM -> ERR_COL
//             min<DATA_LO | max>DATA_HI -> ERR_RANGE
//             min>max -> ERR_ORDER
//             all rules pass -> COMMIT.
//    COMMIT:  wr_en=1, done=1 for exactly one cycle; outputs carry the slots -> IDLE.
//    FAIL:    error=1 for one cycle, err_code latched -> IDLE. wr_en never asserts.
//  - Latency: final token accepted in cycle N -> CHECK in N+1 -> wr_en/done (or error) in N+2.
//  - set_*/data_* are registered. They hold their last value between commands; the settings bank samples only on wr_en.
//  - min==max is legal. row==col==MAX_DIM is legal. Negative data values are legal within DATA_LO..DATA_HI.
//  - rst mid-command: immediate return to IDLE, partial slots cleared, no wr_en.
//  - tok_valid while tok_ready=0 is not consumed (upstream must hold the token).
// STRUCTURE
//  - settings_pkg:
//      typedef enum state_t {IDLE, COLLECT, DRAIN, CHECK, COMMIT, FAIL}
//      typedef enum logic[2:0] err_t {ERR_NONE=0, ERR_TOO_FEW=1, ERR_TOO_MANY=2, ERR_ROW=3, ERR_COL=4, ERR_RANGE=5, ERR_ORDER=6}
//      default limit localparams.
//  - One sub-module: settings_range_check. It is purely combinational: takes the 4 slots plus the parameters and returns err_t. Unit-testable on its own.
// TESTING
//  1. start; tokens 3,4,-2,7 (last on 7) -> wr_en/done one cycle 2 cycles after 7; outputs 3,4,-2,7; error=0.
//  2. start; tokens 0,4,1,9 -> error pulse, err_code=ERR_ROW; wr_en stays 0; outputs keep previous values.
//  3. start; tokens 2,2,8,3 -> ERR_ORDER. Repeat with 2,2,5,5 -> commit succeeds (min==max).
//  4. start; tokens 2,3 with last on 3 -> ERR_TOO_FEW. Then start; 1,1,1,1,1,1 (last on 6th) -> 2 extra tokens consumed, ERR_TOO_MANY.
//  5. Hold tok_valid random 50%, stall-free ready; tokens 5,5,1,9 -> single commit, values exact. start pulses during busy are ignored.
//  6. Assert rst after 2 tokens -> IDLE next cycle, busy=0, tok_ready=0, no wr_en; fresh command 1,2,1,2 then commits correctly.

Source files
------------

// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared types and default limits for the settings command writer
package settings_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DRAIN   = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4,
    FAIL    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_TOO_FEW  = 3'd1,
    ERR_TOO_MANY = 3'd2,
    ERR_ROW      = 3'd3,
    ERR_COL      = 3'd4,
    ERR_RANGE    = 3'd5,
    ERR_ORDER    = 3'd6
  } err_t;

  localparam int signed DEF_MAX_DIM = 5;
  localparam int signed DEF_DATA_LO = -99;
  localparam int signed DEF_DATA_HI = 99;

  // Slot order in the command: row, col, min, max
  localparam int NUM_SLOTS = 4;
  localparam logic [1:0] SLOT_ROW = 2'd0;
  localparam logic [1:0] SLOT_COL = 2'd1;
  localparam logic [1:0] SLOT_MIN = 2'd2;
  localparam logic [1:0] SLOT_MAX = 2'd3;

endpackage

// File: rtl/settings_range_check.sv
// rtl/settings_range_check.sv - combinational legality check of one settings command
module settings_range_check
  import settings_pkg::*;
#(
  parameter int signed MAX_DIM = DEF_MAX_DIM,
  parameter int signed DATA_LO = DEF_DATA_LO,
  parameter int signed DATA_HI = DEF_DATA_HI
) (
  input  logic signed [31:0] row,
  input  logic signed [31:0] col,
  input  logic signed [31:0] dmin,
  input  logic signed [31:0] dmax,
  output err_t               err
);

  // Ordered rule chain: the first rule that fails decides the reported reason
  always_comb begin
    err = ERR_NONE;
    if (row < 32'sd1 || row > MAX_DIM) begin
      err = ERR_ROW;
    end else if (col < 32'sd1 || col > MAX_DIM) begin
      err = ERR_COL;
    end else if (dmin < DATA_LO || dmax > DATA_HI) begin
      err = ERR_RANGE;
    end else if (dmin > dmax) begin
      err = ERR_ORDER;
    end
  end

endmodule

// File: rtl/settings_cmd_writer.sv
// rtl/settings_cmd_writer.sv - collects, checks and commits one 4-token settings command
module settings_cmd_writer
  import settings_pkg::*;
#(
  parameter int signed MAX_DIM = DEF_MAX_DIM,
  parameter int signed DATA_LO = DEF_DATA_LO,
  parameter int signed DATA_HI = DEF_DATA_HI
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic signed [31:0] tok_data,
  input  logic               tok_last,
  output logic               wr_en,
  output logic [31:0]        set_max_row,
  output logic [31:0]        set_max_col,
  output logic [31:0]        data_min,
  output logic [31:0]        data_max,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  err_t               err_q, err_d;
  err_t               chk_err;
  logic signed [31:0] slot_q [NUM_SLOTS];
  logic [31:0]        row_q, col_q, min_q, max_q;
  logic               xfer;
  logic               store;
  logic               load_out;

  settings_range_check #(
    .MAX_DIM (MAX_DIM),
    .DATA_LO (DATA_LO),
    .DATA_HI (DATA_HI)
  ) u_range_check (
    .row  (slot_q[SLOT_ROW]),
    .col  (slot_q[SLOT_COL]),
    .dmin (slot_q[SLOT_MIN]),
    .dmax (slot_q[SLOT_MAX]),
    .err  (chk_err)
  );

  assign tok_ready   = (state_q == COLLECT) || (state_q == DRAIN);
  assign xfer        = tok_valid && tok_ready;
  assign busy        = (state_q != IDLE);
  assign wr_en       = (state_q == COMMIT);
  assign done        = (state_q == COMMIT);
  assign error       = (state_q == FAIL);
  assign err_code    = err_q;
  assign set_max_row = row_q;
  assign set_max_col = col_q;
  assign data_min    = min_q;
  assign data_max    = max_q;

  // Next-state, slot index, error reason and datapath enables
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    store    = 1'b0;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          idx_d   = 2'd0;
          err_d   = ERR_NONE;
        end
      end
      COLLECT: begin
        if (xfer) begin
          store = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = tok_last ? CHECK : DRAIN;
          end else if (tok_last) begin
            state_d = FAIL;
            err_d   = ERR_TOO_FEW;
          end
        end
      end
      DRAIN: begin
        // Surplus tokens are swallowed so the line is fully consumed
        if (xfer && tok_last) begin
          state_d = FAIL;
          err_d   = ERR_TOO_MANY;
        end
      end
      CHECK: begin
        if (chk_err == ERR_NONE) begin
          state_d  = COMMIT;
          load_out = 1'b1;
        end else begin
          state_d = FAIL;
          err_d   = chk_err;
        end
      end
      COMMIT:  state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, slot storage and committed-value registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      err_q   <= ERR_NONE;
      row_q   <= '0;
      col_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (store) begin
        slot_q[idx_q] <= tok_data;
      end
      // Outputs change only on a passing check, so they are stable during wr_en
      if (load_out) begin
        row_q <= slot_q[SLOT_ROW];
        col_q <= slot_q[SLOT_COL];
        min_q <= slot_q[SLOT_MIN];
        max_q <= slot_q[SLOT_MAX];
      end
    end
  end

endmodule

// File: tb/tb_settings_cmd_writer.sv
// tb/tb_settings_cmd_writer.sv - self-checking bench for settings_cmd_writer
module tb_settings_cmd_writer;
  import settings_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               tok_valid;
  logic               tok_ready;
  logic signed [31:0] tok_data;
  logic               tok_last;
  logic               wr_en;
  logic [31:0]        set_max_row;
  logic [31:0]        set_max_col;
  logic [31:0]        data_min;
  logic [31:0]        data_max;
  logic               busy;
  logic               done;
  logic               error;
  logic [2:0]         err_code;

  settings_cmd_writer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_data    (tok_data),
    .tok_last    (tok_last),
    .wr_en       (wr_en),
    .set_max_row (set_max_row),
    .set_max_col (set_max_col),
    .data_min    (data_min),
    .data_max    (data_max),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Last committed values as the bench expects them
  logic [31:0] m_row, m_col, m_min, m_max;

  typedef struct packed {
    logic [5:0][31:0] tok;
    logic [2:0]       n;
    logic             rnd;
    logic [2:0]       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic add(input int t0, input int t1, input int t2, input int t3,
                     input int t4, input int t5, input int n, input bit rnd, input err_t e);
    vec_t v;
    v.tok[0] = t0; v.tok[1] = t1; v.tok[2] = t2;
    v.tok[3] = t3; v.tok[4] = t4; v.tok[5] = t5;
    v.n   = 3'(n);
    v.rnd = rnd;
    v.err = e;
    vecs.push_back(v);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_row"}, set_max_row, m_row);
    chk({tag, "_col"}, set_max_col, m_col);
    chk({tag, "_min"}, data_min, m_min);
    chk({tag, "_max"}, data_max, m_max);
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic run_vec(input vec_t v);
    int i;
    int guard;
    int d;
    bit vld;
    bit rdy;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_code_cleared", err_code, ERR_NONE);
    i = 0;
    guard = 0;
    while (i < int'(v.n) && guard < 200) begin
      vld       = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      tok_valid = vld;
      tok_data  = v.tok[i];
      tok_last  = (i == int'(v.n) - 1);
      if (v.rnd) start = ($urandom_range(0, 1) == 1);
      rdy = tok_ready;
      @(negedge clk);
      if (vld && rdy) i++;
      guard++;
    end
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    start     = 1'b0;
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL token_timeout: accepted %0d tokens, required %0d", i, v.n);
    end
    d = (v.err == ERR_TOO_FEW || v.err == ERR_TOO_MANY) ? 1 : 2;
    for (int k = 1; k < d; k++) begin
      chk("check_cycle_wr_en", wr_en, 0);
      chk("check_cycle_error", error, 0);
      chk("check_cycle_ready", tok_ready, 0);
      @(negedge clk);
    end
    if (v.err == ERR_NONE) begin
      chk("commit_wr_en", wr_en, 1);
      chk("commit_done", done, 1);
      chk("commit_error", error, 0);
      m_row = v.tok[0];
      m_col = v.tok[1];
      m_min = v.tok[2];
      m_max = v.tok[3];
      chk_outputs("commit");
    end else begin
      chk("reject_error", error, 1);
      chk("reject_wr_en", wr_en, 0);
      chk("reject_done", done, 0);
      chk("reject_err_code", err_code, v.err);
      chk_outputs("reject_hold");
    end
    @(negedge clk);
    chk("after_wr_en", wr_en, 0);
    chk("after_error", error, 0);
    chk("after_busy", busy, 0);
    chk("after_err_code", err_code, v.err);
    chk_outputs("after_hold");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tok_valid = 1'b0; tok_data = '0; tok_last = 1'b0;
    m_row = '0; m_col = '0; m_min = '0; m_max = '0;

    //   t0  t1   t2   t3  t4 t5  n rnd expected
    add( 3,  4,  -2,   7,  0, 0,  4, 0, ERR_NONE);
    add( 0,  4,   1,   9,  0, 0,  4, 0, ERR_ROW);
    add( 2,  2,   8,   3,  0, 0,  4, 0, ERR_ORDER);
    add( 2,  2,   5,   5,  0, 0,  4, 0, ERR_NONE);
    add( 2,  3,   0,   0,  0, 0,  2, 0, ERR_TOO_FEW);
    add( 1,  1,   1,   1,  1, 1,  6, 0, ERR_TOO_MANY);
    add( 5,  5,   1,   9,  0, 0,  4, 1, ERR_NONE);
    add( 6,  1,   0,   0,  0, 0,  4, 0, ERR_ROW);
    add( 1,  0,   0,   0,  0, 0,  4, 0, ERR_COL);
    add( 1,  6,   0,   0,  0, 0,  4, 0, ERR_COL);
    add( 1,  1, -100,  0,  0, 0,  4, 0, ERR_RANGE);
    add( 1,  1,   0, 100,  0, 0,  4, 0, ERR_RANGE);
    add( 0,  0, -100, -5,  0, 0,  4, 0, ERR_ROW);
    add( 5,  5,  10, -10,  0, 0,  4, 0, ERR_ORDER);
    add( 4,  5, 100,  50,  0, 0,  4, 0, ERR_ORDER);
    add( 1,  1,   1,   0,  0, 0,  3, 0, ERR_TOO_FEW);
    add( 1,  1, -99,  99,  0, 0,  4, 0, ERR_NONE);
    add( 5,  5,  -3,  -3,  0, 0,  5, 1, ERR_TOO_MANY);
    add( 5,  5, -99, -99,  0, 0,  4, 1, ERR_NONE);

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", tok_ready, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_err_code", err_code, ERR_NONE);
    chk_outputs("reset");
    rst = 1'b0;

    // Tokens offered while idle must not be consumed
    tok_valid = 1'b1; tok_data = 32'sd42; tok_last = 1'b1;
    @(negedge clk);
    chk("idle_ready", tok_ready, 0);
    chk("idle_busy", busy, 0);
    tok_valid = 1'b0; tok_last = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      run_vec(vecs[v]);
    end

    // Reset in the middle of a command after two accepted tokens
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tok_valid = 1'b1; tok_data = 32'sd4; tok_last = 1'b0;
    @(negedge clk);
    tok_data = 32'sd4;
    @(negedge clk);
    tok_valid = 1'b0;
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tok_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    m_row = '0; m_col = '0; m_min = '0; m_max = '0;
    chk_outputs("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_en", wr_en, 0);
    chk("post_rst_busy", busy, 0);

    begin
      vec_t fresh;
      fresh.tok = '0;
      fresh.tok[0] = 32'sd1; fresh.tok[1] = 32'sd2;
      fresh.tok[2] = 32'sd1; fresh.tok[3] = 32'sd2;
      fresh.n = 3'd4; fresh.rnd = 1'b0; fresh.err = ERR_NONE;
      run_vec(fresh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
